led_pattern_gen: RTL and testbench

- Parametrised successor to the board's fixed LED test block. Drives LED_NUM active-high LEDs from one clock.
- Four runtime-selectable patterns: shift, bounce, blink and binary count.
- A programmable tick divider advances the pattern; a PWM stage sets global brightness.
- Sits at the top level between the clock/reset pins and the LED pins; also serves as the standard board bring-up block.

---
 rtl/led_pattern_gen.sv | 123 ++++++++++++
 tb/tb_led_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: shift / bounce / blink / count patterns advanced by a
// programmable tick divider, with a global PWM brightness stage on the outputs.
module led_pattern_gen #(
    parameter int unsigned LED_NUM  = 4,
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PWM_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PWM_W-1:0]   brightness,
    output logic [LED_NUM-1:0] pattern,
    output logic               tick,
    output logic [LED_NUM-1:0] led
);

    typedef enum logic [1:0] {
        SHIFT  = 2'd0,
        BOUNCE = 2'd1,
        BLINK  = 2'd2,
        COUNT  = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int unsigned        CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PWM_W-1:0]   PWM_LAST = PWM_W'((64'd1 << PWM_W) - 64'd2);
    localparam logic [LED_NUM-1:0] PAT_ONE  = LED_NUM'(1);

    mode_t              mode_in;
    mode_t              mode_q;
    dir_t               dir;
    dir_t               dir_next;
    logic [CNT_W-1:0]   cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [LED_NUM-1:0] pat_next;
    logic [LED_NUM-1:0] pat_init;

    assign mode_in = mode_t'(mode);

    always_comb begin
        case (mode_in)
            BLINK:   pat_init = '1;
            COUNT:   pat_init = '0;
            default: pat_init = PAT_ONE;
        endcase
    end

    always_comb begin
        pat_next = pattern;
        dir_next = dir;
        case (mode_q)
            SHIFT:  pat_next = (pattern << 1) | (pattern >> (LED_NUM - 1));
            BOUNCE: begin
                // A single LED has nowhere to bounce; it simply stays lit.
                if (LED_NUM > 1) begin
                    if (dir == UP) begin
                        if (pattern[LED_NUM-1]) begin
                            dir_next = DOWN;
                            pat_next = pattern >> 1;
                        end else begin
                            pat_next = pattern << 1;
                        end
                    end else begin
                        if (pattern[0]) begin
                            dir_next = UP;
                            pat_next = pattern << 1;
                        end else begin
                            pat_next = pattern >> 1;
                        end
                    end
                end
            end
            BLINK:   pat_next = ~pattern;
            default: pat_next = pattern + PAT_ONE;
        endcase
    end

    // Mode reload wins over a coincident tick and runs even while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mode_q  <= SHIFT;
            pattern <= PAT_ONE;
            dir     <= UP;
            tick    <= 1'b0;
        end else if (mode_in != mode_q) begin
            mode_q  <= mode_in;
            cnt     <= '0;
            tick    <= 1'b0;
            dir     <= UP;
            pattern <= pat_init;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt     <= '0;
                tick    <= 1'b1;
                pattern <= pat_next;
                dir     <= dir_next;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
            led     <= pattern & {LED_NUM{pwm_cnt < brightness}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_NUM=4, TICK_DIV=4, PWM_W=3.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] brightness;
    logic [3:0] pattern;
    logic       tick;
    logic [3:0] led;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    led_pattern_gen #(
        .LED_NUM (4),
        .TICK_DIV(4),
        .PWM_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .brightness(brightness),
        .pattern   (pattern),
        .tick      (tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'd0; brightness = 3'd7;
        #2;
        n_total++;
        if (pattern !== 4'b0001) $display("FAIL reset_pattern: got %b want %b", pattern, 4'b0001);
        else n_pass++;
        n_total++;
        if (led !== 4'b0000) $display("FAIL reset_led: got %b want %b", led, 4'b0000);
        else n_pass++;
        n_total++;
        if (tick !== 1'b0) $display("FAIL reset_tick: got %b want %b", tick, 1'b0);
        else n_pass++;
        step();
        step();
        n_total++;
        if (led !== 4'b0000) $display("FAIL reset_led_held: got %b want %b", led, 4'b0000);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_shift();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_pat  = 4'b0001;
        logic [3:0] prev_pat;
        logic       exp_tick;
        for (int unsigned i = 1; i <= 16; i++) begin
            step();
            prev_pat = exp_pat;
            exp_tick = (i % 4 == 0);
            if (exp_tick) exp_pat = exp_seq[i/4 - 1];
            n_total++;
            if (tick !== exp_tick) $display("FAIL shift_tick[%0d]: got %b want %b", i, tick, exp_tick);
            else n_pass++;
            n_total++;
            if (pattern !== exp_pat) $display("FAIL shift_pattern[%0d]: got %b want %b", i, pattern, exp_pat);
            else n_pass++;
            n_total++;
            if (led !== prev_pat) $display("FAIL shift_led_lag[%0d]: got %b want %b", i, led, prev_pat);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                    4'b0010, 4'b0001, 4'b0010};
        mode = 2'd1;
        step();
        n_total++;
        if (pattern !== 4'b0001 || tick !== 1'b0)
            $display("FAIL bounce_load: got %b/%b want %b/%b", pattern, tick, 4'b0001, 1'b0);
        else n_pass++;
        for (int unsigned k = 0; k < 7; k++) begin
            for (int unsigned j = 1; j <= 4; j++) begin
                step();
                n_total++;
                if (tick !== (j == 4)) $display("FAIL bounce_tick[%0d.%0d]: got %b want %b", k, j, tick, (j == 4));
                else n_pass++;
            end
            n_total++;
            if (pattern !== exp_seq[k]) $display("FAIL bounce_pattern[%0d]: got %b want %b", k, pattern, exp_seq[k]);
            else n_pass++;
        end
    endtask

    task automatic test_blink_freeze();
        mode = 2'd2;
        step();
        n_total++;
        if (pattern !== 4'b1111) $display("FAIL blink_load: got %b want %b", pattern, 4'b1111);
        else n_pass++;
        for (int unsigned j = 1; j <= 4; j++) step();
        n_total++;
        if (pattern !== 4'b0000 || tick !== 1'b1)
            $display("FAIL blink_first_tick: got %b/%b want %b/%b", pattern, tick, 4'b0000, 1'b1);
        else n_pass++;
        step();
        step();
        en = 1'b0;
        for (int unsigned j = 0; j < 10; j++) begin
            step();
            n_total++;
            if (tick !== 1'b0 || pattern !== 4'b0000)
                $display("FAIL blink_frozen[%0d]: got %b/%b want %b/%b", j, pattern, tick, 4'b0000, 1'b0);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++;
        if (tick !== 1'b0) $display("FAIL blink_resume_early: got %b want %b", tick, 1'b0);
        else n_pass++;
        step();
        n_total++;
        if (tick !== 1'b1 || pattern !== 4'b1111)
            $display("FAIL blink_resume_tick: got %b/%b want %b/%b", pattern, tick, 4'b1111, 1'b1);
        else n_pass++;
        for (int unsigned j = 1; j <= 4; j++) step();
        n_total++;
        if (tick !== 1'b1 || pattern !== 4'b0000)
            $display("FAIL blink_next_tick: got %b/%b want %b/%b", pattern, tick, 4'b0000, 1'b1);
        else n_pass++;
    endtask

    task automatic test_count();
        logic [3:0] exp_c = 4'b0000;
        mode = 2'd3;
        step();
        n_total++;
        if (pattern !== 4'b0000) $display("FAIL count_load: got %b want %b", pattern, 4'b0000);
        else n_pass++;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 1; j <= 4; j++) step();
            exp_c = exp_c + 4'd1;
            n_total++;
            if (tick !== 1'b1 || pattern !== exp_c)
                $display("FAIL count_step[%0d]: got %b/%b want %b/%b", i, pattern, tick, exp_c, 1'b1);
            else n_pass++;
        end
    endtask

    task automatic test_pwm();
        int unsigned n_on;
        int unsigned n_off;
        mode = 2'd2;
        en   = 1'b0;
        step();
        n_total++;
        if (pattern !== 4'b1111) $display("FAIL pwm_pattern: got %b want %b", pattern, 4'b1111);
        else n_pass++;
        brightness = 3'd3;
        n_on  = 0;
        n_off = 0;
        for (int unsigned j = 0; j < 7; j++) begin
            step();
            if (led === 4'b1111) n_on++;
            else if (led === 4'b0000) n_off++;
        end
        n_total++;
        if (n_on !== 3 || n_off !== 4)
            $display("FAIL pwm_duty3: got on=%0d off=%0d want on=3 off=4", n_on, n_off);
        else n_pass++;
        brightness = 3'd0;
        for (int unsigned j = 0; j < 7; j++) begin
            step();
            n_total++;
            if (led !== 4'b0000) $display("FAIL pwm_off[%0d]: got %b want %b", j, led, 4'b0000);
            else n_pass++;
        end
        brightness = 3'd7;
        for (int unsigned j = 0; j < 7; j++) begin
            step();
            n_total++;
            if (led !== 4'b1111) $display("FAIL pwm_full[%0d]: got %b want %b", j, led, 4'b1111);
            else n_pass++;
        end
    endtask

    task automatic test_mode_change_and_reset();
        mode = 2'd0;
        en   = 1'b1;
        step();
        n_total++;
        if (pattern !== 4'b0001) $display("FAIL mc_shift_load: got %b want %b", pattern, 4'b0001);
        else n_pass++;
        step();
        step();
        mode = 2'd3;
        step();
        n_total++;
        if (pattern !== 4'b0000 || tick !== 1'b0)
            $display("FAIL mc_load: got %b/%b want %b/%b", pattern, tick, 4'b0000, 1'b0);
        else n_pass++;
        for (int unsigned j = 1; j <= 4; j++) begin
            step();
            n_total++;
            if (tick !== (j == 4)) $display("FAIL mc_tick[%0d]: got %b want %b", j, tick, (j == 4));
            else n_pass++;
        end
        n_total++;
        if (pattern !== 4'b0001) $display("FAIL mc_first_count: got %b want %b", pattern, 4'b0001);
        else n_pass++;
        for (int unsigned j = 1; j <= 4; j++) step();
        n_total++;
        if (pattern !== 4'b0010 || tick !== 1'b1 || led !== 4'b0001)
            $display("FAIL mc_pre_reset: got %b/%b/%b want %b/%b/%b",
                     pattern, tick, led, 4'b0010, 1'b1, 4'b0001);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (pattern !== 4'b0001 || led !== 4'b0000 || tick !== 1'b0)
            $display("FAIL async_reset: got %b/%b/%b want %b/%b/%b",
                     pattern, led, tick, 4'b0001, 4'b0000, 1'b0);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        n_total++;
        if (pattern !== 4'b0000 || tick !== 1'b0)
            $display("FAIL post_reset_load: got %b/%b want %b/%b", pattern, tick, 4'b0000, 1'b0);
        else n_pass++;
        for (int unsigned j = 1; j <= 4; j++) begin
            step();
            n_total++;
            if (tick !== (j == 4)) $display("FAIL post_reset_tick[%0d]: got %b want %b", j, tick, (j == 4));
            else n_pass++;
        end
        n_total++;
        if (pattern !== 4'b0001) $display("FAIL post_reset_pattern: got %b want %b", pattern, 4'b0001);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_bounce();
        test_blink_freeze();
        test_count();
        test_pwm();
        test_mode_change_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
